ex_mem: RTL
===========

EX_MEM -- requirements
Module: ex_mem

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15, the maximum WAIT cycles before a memory error is flagged.
REQ-002 SHALL have ports:
- clk  input  1  sole clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- aluResult  input  16  EX result; memory address for loads and stores.
- storeData  input  16  store data from EX.
- memRead, memWrite, memToReg, regWrite  input  1 each  EX control.
- writereg  input  3  destination register.
- inValid  input  1  EX holds a real instruction.
- flush  input  1  load a bubble instead of EX contents.
- memAck  input  1  memory completed the current request.
- memRdData  input  16  load data, valid when memAck=1.
- aluResultOut, storeDataOut, memDataOut  output  16 each  registered values.
- memReadOut, memWriteOut, memToRegOut, regWriteOut  output  1 each  registered control.
- writeregOut  output  3  registered destination.
- validOut  output  1  stage holds a real instruction.
- memReq  output  1  one-cycle memory request strobe.
- stall  output  1  upstream must hold its contents.
- memErr  output  1  sticky timeout flag.

Function
REQ-003 SHALL implement FSM states IDLE, REQ and WAIT; stall = (state != IDLE).
REQ-004 In IDLE, each rising edge SHALL load the stage register from the inputs, with validOut <= inValid & ~flush.
REQ-005 When flush=1 in IDLE, the stage SHALL load a bubble: validOut=0 and all control and data outputs 0.
REQ-006 When a loaded entry has validOut=1 and memRead|memWrite, the next state SHALL be REQ; otherwise the state SHALL stay IDLE.
REQ-007 In REQ, memReq SHALL be 1 for exactly that cycle, and the next state SHALL be WAIT.
REQ-008 memReq SHALL be 0 in IDLE and WAIT.
REQ-009 memAck SHALL be sampled only in WAIT; memAck in IDLE or REQ SHALL be ignored.
REQ-010 In WAIT with memAck=1, the next state SHALL be IDLE; if memReadOut=1, memDataOut SHALL capture memRdData.
REQ-011 While state != IDLE, all stage outputs except memDataOut SHALL hold, and flush and the EX inputs SHALL be ignored.
REQ-012 A 4-bit WAIT counter SHALL clear on entry to WAIT and increment each WAIT cycle without memAck.
REQ-013 When the WAIT counter reaches TIMEOUT without memAck, the FSM SHALL go to IDLE, set memErr=1 and clear validOut.
REQ-014 memErr SHALL stay set until reset.
REQ-015 Total latency SHALL be:
- non-memory instruction: 1 cycle EX->outputs;
- memory instruction: 1 cycle + REQ cycle + WAIT cycles up to and including the memAck cycle.
REQ-016 Back-to-back memory instructions SHALL each get their own REQ; no request SHALL be lost or duplicated.
REQ-017 A non-memory instruction with validOut=1 SHALL never assert memReq.

Reset
REQ-018 While rst=0, regardless of clk, the block SHALL set:
- state = IDLE and the WAIT counter = 0;
- all 16-bit outputs, writeregOut and all control outputs = 0;
- validOut, memReq, stall and memErr = 0.
REQ-019 Reset asserted in REQ or WAIT SHALL abandon the request; after release, memAck SHALL be ignored until a new REQ.

Structure
REQ-020 A shared package SHALL hold the FSM state encoding (2 bits), the data width constant 16 and the default TIMEOUT.
REQ-021 The FSM and WAIT counter SHALL live in one sub-module, ex_mem_ctrl; the stage storage SHALL be enable-gated flops in ex_mem.

Verification
REQ-022 The bench SHALL cover these scenarios:
- ALU op aluResult=0x1234, regWrite=1, writereg=5, inValid=1 -> next cycle aluResultOut=0x1234, writeregOut=5, validOut=1, memReq and stall never 1.
- Load, aluResult=0x0040, memAck 3 cycles after memReq with memRdData=0xBEEF -> memReq high exactly 1 cycle; stall high from the REQ cycle through the ack cycle; memDataOut=0xBEEF; the next instruction is loaded the cycle after the ack.
- flush=1 together with a valid store in IDLE -> validOut=0, memWriteOut=0, no memReq.
- flush=1 while in WAIT -> ignored; the stored entry is unchanged and completes on memAck.
- Store with memAck never asserted (TIMEOUT=15) -> after 15 WAIT cycles memErr=1, validOut=0, state IDLE, stall=0; memErr remains 1.
- rst=0 asynchronously mid-WAIT -> all outputs 0 immediately; a later memAck produces no capture and no state change.

Source files
------------

// File: rtl/ex_mem_pkg.sv
// Shared constants, FSM encoding and stage payload for the EX/MEM pipeline register.
package ex_mem_pkg;

  localparam int unsigned DATA_W      = 16;
  localparam int unsigned REG_W       = 3;
  localparam int unsigned CNT_W       = 4;
  localparam int unsigned TIMEOUT_DEF = 15;

  // Bit 1 doubles as the stall flag and bit 0 as the request strobe.
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_WAIT = 2'b10;
  localparam logic [1:0] ST_REQ  = 2'b11;

  typedef struct packed {
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] sdata;
    logic              mem_rd;
    logic              mem_wr;
    logic              mem_to_reg;
    logic              reg_wr;
    logic [REG_W-1:0]  wreg;
  } stage_t;

endpackage

// File: rtl/ex_mem_ctrl.sv
// Memory handshake FSM (IDLE/REQ/WAIT) with WAIT timeout counter and sticky error.
module ex_mem_ctrl
  import ex_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start_i,
  input  logic ack_i,
  output logic mem_req_o,
  output logic stall_o,
  output logic mem_err_o,
  output logic load_en_c_o,
  output logic done_c_o,
  output logic timeout_c_o
);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             err_q, err_d;

  assign cnt_inc = cnt_q + CNT_W'(1);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    load_en_c_o = 1'b0;
    done_c_o    = 1'b0;
    timeout_c_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        load_en_c_o = 1'b1;
        if (start_i) state_d = ST_REQ;
      end
      ST_REQ: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // An ack on the final allowed cycle still wins over the timeout.
        if (ack_i) begin
          done_c_o = 1'b1;
          state_d  = ST_IDLE;
        end else if (cnt_inc == CNT_W'(TIMEOUT)) begin
          timeout_c_o = 1'b1;
          err_d       = 1'b1;
          cnt_d       = cnt_inc;
          state_d     = ST_IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign mem_req_o = state_q[0];
  assign stall_o   = state_q[1];
  assign mem_err_o = err_q;

endmodule

// File: rtl/ex_mem.sv
// EX/MEM pipeline register that stalls upstream while a load/store handshake is in flight.
module ex_mem
  import ex_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] aluResult,
  input  logic [DATA_W-1:0] storeData,
  input  logic              memRead,
  input  logic              memWrite,
  input  logic              memToReg,
  input  logic              regWrite,
  input  logic [REG_W-1:0]  writereg,
  input  logic              inValid,
  input  logic              flush,
  input  logic              memAck,
  input  logic [DATA_W-1:0] memRdData,
  output logic [DATA_W-1:0] aluResultOut,
  output logic [DATA_W-1:0] storeDataOut,
  output logic [DATA_W-1:0] memDataOut,
  output logic              memReadOut,
  output logic              memWriteOut,
  output logic              memToRegOut,
  output logic              regWriteOut,
  output logic [REG_W-1:0]  writeregOut,
  output logic              validOut,
  output logic              memReq,
  output logic              stall,
  output logic              memErr
);

  stage_t            stage_q, stage_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] mem_data_q, mem_data_d;
  logic              start_c, load_en_c, done_c, timeout_c;

  assign start_c = inValid & ~flush & (memRead | memWrite);

  ex_mem_ctrl #(.TIMEOUT(TIMEOUT)) u_ctrl (
    .clk         (clk),
    .rst_n       (rst),
    .start_i     (start_c),
    .ack_i       (memAck),
    .mem_req_o   (memReq),
    .stall_o     (stall),
    .mem_err_o   (memErr),
    .load_en_c_o (load_en_c),
    .done_c_o    (done_c),
    .timeout_c_o (timeout_c)
  );

  // Next stage contents; a flush turns the incoming slot into an all-zero bubble.
  always_comb begin
    stage_d.alu        = aluResult;
    stage_d.sdata      = storeData;
    stage_d.mem_rd     = memRead;
    stage_d.mem_wr     = memWrite;
    stage_d.mem_to_reg = memToReg;
    stage_d.reg_wr     = regWrite;
    stage_d.wreg       = writereg;
    if (flush) stage_d = '0;

    valid_d = valid_q;
    if (load_en_c) valid_d = inValid & ~flush;
    if (timeout_c) valid_d = 1'b0;

    mem_data_d = mem_data_q;
    if (load_en_c && flush)         mem_data_d = '0;
    if (done_c && stage_q.mem_rd)   mem_data_d = memRdData;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           stage_q <= '0;
    else if (load_en_c) stage_q <= stage_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q    <= 1'b0;
      mem_data_q <= '0;
    end else begin
      valid_q    <= valid_d;
      mem_data_q <= mem_data_d;
    end
  end

  assign aluResultOut = stage_q.alu;
  assign storeDataOut = stage_q.sdata;
  assign memReadOut   = stage_q.mem_rd;
  assign memWriteOut  = stage_q.mem_wr;
  assign memToRegOut  = stage_q.mem_to_reg;
  assign regWriteOut  = stage_q.reg_wr;
  assign writeregOut  = stage_q.wreg;
  assign validOut     = valid_q;
  assign memDataOut   = mem_data_q;

endmodule
